// File: rtl/uart_tx_fifo.sv
// UART transmitter with an integrated transmit FIFO. Accepts words over a
// valid/ready handshake and sends queued frames back-to-back on the tx line.
module uart_tx_fifo #(
    parameter int    CLK_FREQ   = 100_000_000,
    parameter int    BAUD_RATE  = 9600,
    parameter int    DATA_BIT   = 8,
    parameter int    STOP_BIT   = 1,
    parameter int    CHECK_BIT  = 0,
    parameter string CHECK_MODE = "EVEN",
    parameter int    FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_BIT-1:0]           tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx,
    output logic                          tx_busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int BAUD_CNT_MAX = CLK_FREQ / BAUD_RATE;
    localparam int BW           = (BAUD_CNT_MAX > 1) ? $clog2(BAUD_CNT_MAX) : 1;
    localparam int PW           = $clog2(FIFO_DEPTH);

    localparam logic [BW-1:0] BAUD_LAST  = BW'(BAUD_CNT_MAX - 1);
    localparam logic [3:0]    DATA_LAST  = 4'(DATA_BIT - 1);
    localparam logic [3:0]    STOP_LAST  = 4'(STOP_BIT - 1);
    localparam bit            USE_PARITY = (CHECK_BIT != 0);
    localparam bit            ODD_PARITY = (CHECK_MODE == "ODD");

    // Handshake: a word is written on any rising edge where tx_valid and
    // tx_ready are both high; a producer seeing tx_ready low holds tx_data.

    typedef enum logic [2:0] {IDLE, START, DATA, CHECK, STOP} state_t;

    state_t state, state_next;

    logic [DATA_BIT-1:0] mem [FIFO_DEPTH];
    logic [PW:0]         wr_ptr, rd_ptr;
    logic                empty, full, push, pop;
    logic [DATA_BIT-1:0] head;

    logic [BW-1:0]       baud_cnt;
    logic [3:0]          bit_cnt;
    logic                baud_wrap;
    logic [DATA_BIT-1:0] shift;
    logic                parity;
    logic                done_next;

    // FIFO: pointers carry one extra wrap bit to tell full from empty.
    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign tx_ready   = !full && !rst;
    assign push       = tx_valid && tx_ready;
    assign head       = mem[rd_ptr[PW-1:0]];
    assign fifo_count = wr_ptr - rd_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[PW-1:0]] <= tx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    assign baud_wrap = (baud_cnt == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                if (baud_wrap) state_next = DATA;
            end
            DATA: begin
                if (baud_wrap && bit_cnt == DATA_LAST) begin
                    state_next = USE_PARITY ? CHECK : STOP;
                end
            end
            CHECK: begin
                if (baud_wrap) state_next = STOP;
            end
            STOP: begin
                if (baud_wrap && bit_cnt == STOP_LAST) begin
                    done_next = 1'b1;
                    // Chain straight into the next start bit when a word is waiting.
                    if (!empty) begin
                        pop        = 1'b1;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs are registered from the current state, so tx, tx_busy and
    // tx_done all trail the state register by exactly one clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            parity   <= 1'b0;
            tx       <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            if (state == IDLE || baud_wrap) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end

            if (state_next != state) begin
                bit_cnt <= '0;
            end else if (baud_wrap) begin
                bit_cnt <= bit_cnt + 1'b1;
            end

            if (pop) begin
                shift  <= head;
                parity <= ODD_PARITY ? ~^head : ^head;
            end else if (state == DATA && baud_wrap) begin
                shift <= shift >> 1;
            end

            case (state)
                START:   tx <= 1'b0;
                DATA:    tx <= shift[0];
                CHECK:   tx <= parity;
                default: tx <= 1'b1;
            endcase

            tx_busy <= (state != IDLE);
            tx_done <= done_next;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: 8N1, 8E1, 8O1 and 7N2 instances at 10 clocks
// per bit with a 4-entry FIFO; frames are checked sample-by-sample on the line.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid_w [4];
    logic [7:0] data_w  [3];
    logic [6:0] data7;
    logic       tx_w    [4];
    logic       busy_w  [4];
    logic       done_w  [4];
    logic       ready_w [4];
    logic [2:0] count_w [4];

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] words [6] = '{8'h11, 8'h22, 8'hC3, 8'h5A, 8'hF0, 8'h3C};

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BIT(8), .STOP_BIT(1),
                   .CHECK_BIT(0), .CHECK_MODE("EVEN"), .FIFO_DEPTH(4)) u_8n1 (
        .clk(clk), .rst(rst), .tx_data(data_w[0]), .tx_valid(valid_w[0]), .tx_ready(ready_w[0]),
        .tx(tx_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0]), .fifo_count(count_w[0]));

    uart_tx_fifo #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BIT(8), .STOP_BIT(1),
                   .CHECK_BIT(1), .CHECK_MODE("EVEN"), .FIFO_DEPTH(4)) u_8e1 (
        .clk(clk), .rst(rst), .tx_data(data_w[1]), .tx_valid(valid_w[1]), .tx_ready(ready_w[1]),
        .tx(tx_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1]), .fifo_count(count_w[1]));

    uart_tx_fifo #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BIT(8), .STOP_BIT(1),
                   .CHECK_BIT(1), .CHECK_MODE("ODD"), .FIFO_DEPTH(4)) u_8o1 (
        .clk(clk), .rst(rst), .tx_data(data_w[2]), .tx_valid(valid_w[2]), .tx_ready(ready_w[2]),
        .tx(tx_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2]), .fifo_count(count_w[2]));

    uart_tx_fifo #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BIT(7), .STOP_BIT(2),
                   .CHECK_BIT(0), .CHECK_MODE("EVEN"), .FIFO_DEPTH(4)) u_7n2 (
        .clk(clk), .rst(rst), .tx_data(data7), .tx_valid(valid_w[3]), .tx_ready(ready_w[3]),
        .tx(tx_w[3]), .tx_busy(busy_w[3]), .tx_done(done_w[3]), .fifo_count(count_w[3]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present a word at a negedge, hold it until tx_ready, return one negedge
    // after the accepting edge with tx_valid dropped.
    task automatic push(input int k, input logic [7:0] w);
        int t;
        t = 0;
        valid_w[k] = 1'b1;
        if (k == 3) data7 = w[6:0];
        else        data_w[k] = w;
        while (ready_w[k] !== 1'b1 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("push_wait", 32'(t < 3000), 1);
        @(negedge clk);
        valid_w[k] = 1'b0;
    endtask

    // Wait for the start bit, then check every clock of the frame on the line.
    task automatic run_frame(input int k, input int nd, input int np, input int ns,
                             input logic [8:0] exp_w, input logic exp_p,
                             input int exp_gap, input string tag);
        int   gap, bad, busy_bad, done_cnt, done_at, len, b;
        logic e;
        gap = 0; bad = 0; busy_bad = 0; done_cnt = 0; done_at = -1;
        while (tx_w[k] !== 1'b0 && gap < 2000) begin
            @(negedge clk);
            gap++;
        end
        check({tag, "_gap"}, gap, exp_gap);
        len = (1 + nd + np + ns) * 10;
        for (int i = 0; i < len; i++) begin
            b = i / 10;
            if (b == 0)                     e = 1'b0;
            else if (b <= nd)               e = exp_w[b-1];
            else if (np != 0 && b == nd + 1) e = exp_p;
            else                            e = 1'b1;
            if (tx_w[k] !== e)      bad++;
            if (busy_w[k] !== 1'b1) busy_bad++;
            if (done_w[k] === 1'b1) begin
                done_cnt++;
                done_at = i;
            end
            @(negedge clk);
        end
        check({tag, "_bits"}, bad, 0);
        check({tag, "_busy"}, busy_bad, 0);
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_done_pos"}, done_at, len - 1);
    endtask

    initial begin
        int t;
        int cnt_bad;
        int lows;
        for (int i = 0; i < 4; i++) valid_w[i] = 1'b0;
        for (int i = 0; i < 3; i++) data_w[i] = 8'h00;
        data7 = 7'h00;
        rst   = 1'b1;
        repeat (3) @(negedge clk);

        check("rst_tx", tx_w[0], 1);
        check("rst_busy", busy_w[0], 0);
        check("rst_done", done_w[0], 0);
        check("rst_count", count_w[0], 0);
        check("rst_ready", ready_w[0], 0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready_after", ready_w[0], 1);

        // 8N1 single word 0xA5
        push(0, 8'hA5);
        run_frame(0, 8, 0, 1, 9'h0A5, 1'b0, 2, "t1");
        check("t1_idle_tx", tx_w[0], 1);
        check("t1_idle_busy", busy_w[0], 0);

        // Even parity: second push coincides with the first pop
        push(1, 8'h07);
        push(1, 8'h00);
        check("t2_pushpop_count", count_w[1], 1);
        run_frame(1, 8, 1, 1, 9'h007, 1'b1, 1, "t2e_07");
        run_frame(1, 8, 1, 1, 9'h000, 1'b0, 0, "t2e_00");

        // Odd parity
        push(2, 8'h07);
        run_frame(2, 8, 1, 1, 9'h007, 1'b0, 2, "t2o_07");

        // 7 data bits, 2 stop bits; bit 7 of the driven byte never reaches the port
        push(3, 8'hD5);
        run_frame(3, 7, 0, 2, 9'h055, 1'b0, 2, "t4");

        // Six words back-to-back; the last (0x3C) is held while the FIFO is full
        fork
            begin
                for (int i = 0; i < 5; i++) push(0, words[i]);
                check("t3_full_ready", ready_w[0], 0);
                check("t3_full_count", count_w[0], 4);
                valid_w[0] = 1'b1;
                data_w[0]  = words[5];
                t = 0;
                cnt_bad = 0;
                while (ready_w[0] !== 1'b1 && t < 3000) begin
                    if (count_w[0] !== 3'd4) cnt_bad++;
                    @(negedge clk);
                    t++;
                end
                check("t6_wait_bounded", 32'(t < 3000), 1);
                check("t6_count_held", cnt_bad, 0);
                check("t6_room", count_w[0], 3);
                @(negedge clk);
                valid_w[0] = 1'b0;
                check("t6_accepted", count_w[0], 4);
            end
            begin
                for (int i = 0; i < 6; i++) begin
                    run_frame(0, 8, 0, 1, {1'b0, words[i]}, 1'b0, (i == 0) ? 3 : 0,
                              $sformatf("t3_f%0d", i));
                end
            end
        join
        check("t3_end_count", count_w[0], 0);
        check("t3_end_busy", busy_w[0], 0);
        lows = 0;
        repeat (150) begin
            if (tx_w[0] !== 1'b1) lows++;
            @(negedge clk);
        end
        check("t6_no_extra_frame", lows, 0);

        // Reset during data bit 3 with two words queued
        push(0, 8'h81);
        push(0, 8'h42);
        push(0, 8'h24);
        check("t5_queued", count_w[0], 2);
        t = 0;
        while (tx_w[0] !== 1'b0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("t5_start_seen", 32'(t < 100), 1);
        repeat (45) @(negedge clk);
        check("t5_pre_busy", busy_w[0], 1);
        check("t5_pre_tx", tx_w[0], 0);
        rst = 1'b1;
        @(negedge clk);
        check("t5_tx", tx_w[0], 1);
        check("t5_busy", busy_w[0], 0);
        check("t5_count", count_w[0], 0);
        check("t5_ready_in_rst", ready_w[0], 0);
        rst = 1'b0;
        @(negedge clk);
        check("t5_ready_after", ready_w[0], 1);
        push(0, 8'h96);
        run_frame(0, 8, 0, 1, 9'h096, 1'b0, 2, "t5_after");
        check("t5_end_count", count_w[0], 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
